// File: rtl/h80cpu_uart_tx_pkg.sv
// rtl/h80cpu_uart_tx_pkg.sv - H80 UART shared types/constants; H80_UART_TX_PARITY_EN adds the PARITY state
package h80_uart_pkg;

`ifdef H80_UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;
    localparam int FRAME_BITS = 10;
`endif

    localparam int DATA_BITS = 8;
    localparam int TIMER_W   = 16;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/h80cpu_uart_tx_if.sv
// rtl/h80cpu_uart_tx_if.sv - byte write handshake from the I/O decoder into the UART transmitter
interface h80cpu_uart_tx_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/h80cpu_uart_tx_fifo.sv
// rtl/h80cpu_uart_tx_fifo.sv - synchronous power-of-two FIFO, shared by the UART transmit and receive paths
module h80_fifo_sync
    import h80_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Overflowing pushes and underflowing pops are silently ignored.
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_level == LW'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/h80cpu_uart_tx.sv
// rtl/h80cpu_uart_tx.sv - FIFO-fed UART transmitter, 8N1 by default; define H80_UART_TX_PARITY_EN for 8E1
module h80cpu_uart_tx
    import h80_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    h80cpu_uart_tx_if.slave                    wr,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic                               busy,
    output logic                               uart_txp
);
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic               r_txp;
    logic               r_busy;
    logic               w_txp;
    logic               w_tick;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [7:0]         w_head;

    assign w_push      = wr.wr_valid && !w_full;
    assign wr.wr_ready = !w_full;
    assign w_tick      = (r_timer == '0);
    assign uart_txp    = r_txp;
    assign busy        = r_busy;

    h80_fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (wr.wr_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_pop         = 1'b0;
        if (!w_tick) begin
            w_timer_nxt = r_timer - 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_state_nxt   = ST_START;
                    w_timer_nxt   = BIT_LAST;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_timer_nxt   = BIT_LAST;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_timer_nxt = BIT_LAST;
                    if (r_bit_idx == IDX_LAST) begin
`ifdef H80_UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
`ifdef H80_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_timer_nxt = BIT_LAST;
                end
            end
`endif
            ST_STOP: begin
                // Chain straight into the next START so queued bytes leave with no idle gap.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_state_nxt   = ST_START;
                        w_timer_nxt   = BIT_LAST;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_txp = 1'b1;
        case (r_state)
            ST_START:  w_txp = 1'b0;
            ST_DATA:   w_txp = r_shift[r_bit_idx];
`ifdef H80_UART_TX_PARITY_EN
            ST_PARITY: w_txp = ^r_shift;
`endif
            default:   w_txp = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txp     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            if (w_pop) begin
                r_shift <= w_head;
            end
            r_txp  <= w_txp;
            r_busy <= (r_state != ST_IDLE) || !w_empty;
        end
    end
endmodule

// File: tb/tb_h80cpu_uart_tx.sv
// tb/tb_h80cpu_uart_tx.sv - scoreboard bench for h80cpu_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_h80cpu_uart_tx;
    import h80_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = CPB * FRAME_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fifo_level;
    logic       busy;
    logic       uart_txp;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    int         starts [$];
    int         frames_done = 0;
    int         abort_seq = 0;

    h80cpu_uart_tx_if wr_if ();

    h80cpu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_if),
        .fifo_level (fifo_level),
        .busy       (busy),
        .uart_txp   (uart_txp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(t < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    // Line receiver: every bit sampled on all CPB cycles, must hold steady.
    logic                  prev_tx = 1'b1;
    logic [FRAME_BITS-1:0] m_bits;
    logic                  m_glitch;
    logic [7:0]            m_exp;
    int                    m_c0;
    int                    m_seq;
    always begin
        @(negedge clk);
        if (!reset && prev_tx && !uart_txp) begin
            m_c0     = cyc;
            m_seq    = abort_seq;
            m_glitch = 1'b0;
            starts.push_back(m_c0);
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int s = 0; s < CPB; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (s == 0) m_bits[b] = uart_txp;
                    else if (uart_txp !== m_bits[b]) m_glitch = 1'b1;
                end
            end
            if (m_seq == abort_seq) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("start_bit", 32'(m_bits[0]), 0);
                    check("data_byte", 32'(m_bits[8:1]), 32'(m_exp));
`ifdef H80_UART_TX_PARITY_EN
                    check("parity_bit", 32'(m_bits[9]), 32'(^m_exp));
`endif
                    check("stop_bit", 32'(m_bits[FRAME_BITS-1]), 1);
                    check("bit_stable", 32'(m_glitch), 0);
                    frames_done++;
                end
            end
        end
        prev_tx = uart_txp;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int t;
        int c0;
        int fd;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txp", 32'(uart_txp), 1);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(wr_if.wr_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // single byte latency and busy timing
        base = starts.size();
        n = cyc + 1;
        exp_q.push_back(8'h55);
        push_byte(8'h55);
        t = 0;
        while (starts.size() == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("latency_start", (starts.size() > base) ? 32'(starts[base]) : 32'hffff_ffff, 32'(n + 2));
        while (cyc < n + 41) @(negedge clk);
        check("busy_before_end", 32'(busy), 1);
        @(negedge clk);
        check("busy_fall", 32'(busy), 0);
        wait_drain("drain_single");

        // back-to-back frames
        base = starts.size();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        wait_drain("drain_b2b");
        check("b2b_frames", 32'(starts.size() - base), 3);
        if (starts.size() >= base + 3) begin
            check("b2b_gap1", 32'(starts[base+1] - starts[base]), 32'(FLEN));
            check("b2b_gap2", 32'(starts[base+2] - starts[base+1]), 32'(FLEN));
        end

        // overflow: sixth byte dropped
        fd = frames_done;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'h60 + 8'(k));
            push_byte(8'h60 + 8'(k));
        end
        check("full_level", 32'(fifo_level), 4);
        check("full_ready", 32'(wr_if.wr_ready), 0);
        push_byte(8'h65);
        check("full_level_hold", 32'(fifo_level), 4);
        wait_drain("drain_full");
        check("full_frames", 32'(frames_done - fd), 5);

        // reset mid-frame with bytes queued, write during reset
        base = starts.size();
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        t = 0;
        while (starts.size() == base && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("abort_frame_started", 32'(starts.size() > base), 1);
        if (starts.size() > base) begin
            c0 = starts[base];
            while (cyc < c0 + 12) @(negedge clk);
        end
        reset = 1'b1;
        abort_seq++;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h77;
        @(negedge clk);
        check("abort_txp", 32'(uart_txp), 1);
        check("abort_level", 32'(fifo_level), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        wr_if.wr_valid = 1'b0;
        repeat (150) @(negedge clk);
        check("abort_no_frames", 32'(starts.size() - base), 1);
        check("abort_idle_txp", 32'(uart_txp), 1);
        check("abort_idle_busy", 32'(busy), 0);
        check("abort_idle_level", 32'(fifo_level), 0);

`ifdef H80_UART_TX_PARITY_EN
        base = starts.size();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        push_byte(8'h07);
        push_byte(8'h03);
        wait_drain("drain_parity");
        check("parity_frames", 32'(starts.size() - base), 2);
        if (starts.size() >= base + 2) begin
            check("parity_len", 32'(starts[base+1] - starts[base]), 44);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
